// File: rtl/gamma_pkg.sv
// Shared constants for the gamma-ROM lookup path and the round-robin pointer helper.
package gamma_pkg;

    localparam int unsigned GAMMA_ADDR_WIDTH  = 8;
    localparam int unsigned GAMMA_DATA_WIDTH  = 8;
    localparam int unsigned GAMMA_ROM_LATENCY = 2;

    localparam int unsigned CH_R = 0;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 2;

    // Pointer value that follows a grant to idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = 32'(ptr) + 32'(k);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/gamma_rom_arbiter.sv
// Shares one synchronous gamma ROM between NUM_REQ pixel channels; round-robin grant,
// registered ROM address and a one-hot tag pipeline that routes each word back.
module gamma_rom_arbiter
    import gamma_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_WIDTH  = GAMMA_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = GAMMA_DATA_WIDTH,
    parameter int unsigned ROM_LATENCY = GAMMA_ROM_LATENCY
) (
    input  logic                          clk,
    input  logic                          tb_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_rd_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TAG_DEPTH = 1 + ROM_LATENCY;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] tag_pipe [TAG_DEPTH];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (grant_idx)
    );

    // No handshake is offered while reset is held, so nothing is accepted then lost.
    assign grant     = tb_rst ? '0 : arb_grant;
    assign req_ready = grant;

    // Pointer, ROM address and tag pipe; the tag pipe never stalls.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            ptr      <= '0;
            rom_addr <= '0;
            for (int s = 0; s < int'(TAG_DEPTH); s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            if (|grant) begin
                ptr      <= PTR_W'(rr_next(32'(grant_idx), NUM_REQ));
                rom_addr <= req_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            end
            tag_pipe[0] <= grant;
            for (int s = 1; s < int'(TAG_DEPTH); s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign rsp_valid = tag_pipe[TAG_DEPTH-1];
    assign rsp_data  = rom_rd_data;

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < int'(TAG_DEPTH); s++) begin
            busy = busy | (|tag_pipe[s]);
        end
    end

endmodule

// File: tb/tb_gamma_rom_arbiter.sv
// Directed bench for gamma_rom_arbiter against an identity ROM with output register.
`timescale 1ns/1ps
module tb_gamma_rom_arbiter;

    logic        clk;
    logic        tb_rst;
    logic [2:0]  req_valid;
    logic [23:0] req_addr;
    logic [2:0]  req_ready;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_rd_data;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic [7:0]  rom_q1;

    int n_checks = 0;
    int n_err    = 0;

    gamma_rom_arbiter #(
        .NUM_REQ     (3),
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .ROM_LATENCY (2)
    ) dut (
        .clk         (clk),
        .tb_rst      (tb_rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Identity ROM, 2-cycle addr-to-data (address reg + output reg).
    always @(posedge clk) begin
        rom_q1      <= rom_addr;
        rom_rd_data <= rom_q1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Invariants sampled every cycle outside reset.
    always @(negedge clk) begin
        if (tb_rst === 1'b0) begin
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            check("rsp_onehot",   32'($countones(rsp_valid) <= 1), 32'd1);
            check("ready_implies_valid", 32'(req_ready & ~req_valid), 32'd0);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        tb_rst    = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_addr",  32'(rom_addr),  32'd0);
        check("rst_rsp",   32'(rsp_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        @(posedge clk); #1;
        tb_rst = 1'b0;
    endtask

    initial begin
        tb_rst    = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        repeat (2) @(posedge clk);

        // 1: single requester streaming 0x00..0xFF, response 3 cycles later
        do_reset();
        for (int i = 0; i < 259; i++) begin
            @(posedge clk); #1;
            req_valid = (i < 256) ? 3'b001 : 3'b000;
            req_addr  = {16'h0, 8'(i)};
            @(negedge clk);
            if (i < 256) check("t1_ready", 32'(req_ready), 32'd1);
            if (i >= 3) begin
                check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
                check("t1_rsp_data",  32'(rsp_data),  32'(i - 3));
            end else begin
                check("t1_rsp_idle", 32'(rsp_valid), 32'd0);
            end
        end

        // 2: all three requesters active, grants rotate 0,1,2
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            req_valid = 3'b111;
            req_addr  = {8'h30, 8'h20, 8'h10};
            @(negedge clk);
            check("t2_ready", 32'(req_ready), 32'(1 << (k % 3)));
            if (k >= 3) begin
                check("t2_rsp_valid", 32'(rsp_valid), 32'(1 << ((k - 3) % 3)));
                check("t2_rsp_data",  32'(rsp_data),  32'(8'h10 * ((k - 3) % 3 + 1)));
            end
        end

        // 3: G and B only from ptr=0 -> G,B,G,B; R never answered
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            req_valid = 3'b110;
            req_addr  = {8'h30, 8'h20, 8'h10};
            @(negedge clk);
            check("t3_ready", 32'(req_ready), (k % 2 == 0) ? 32'b010 : 32'b100);
            if (k >= 3) begin
                check("t3_rsp_valid", 32'(rsp_valid), ((k - 3) % 2 == 0) ? 32'b010 : 32'b100);
                check("t3_rsp_data",  32'(rsp_data),  ((k - 3) % 2 == 0) ? 32'h20 : 32'h30);
            end
        end

        // 4: sparse single lookup at cycle 5, busy over cycles 6..8, response at 8
        do_reset();
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            req_valid = (k == 5) ? 3'b001 : 3'b000;
            req_addr  = {16'h0, 8'hA5};
            @(negedge clk);
            check("t4_ready", 32'(req_ready), (k == 5) ? 32'd1 : 32'd0);
            check("t4_busy",  32'(busy), (k >= 6 && k <= 8) ? 32'd1 : 32'd0);
            check("t4_rsp_valid", 32'(rsp_valid), (k == 8) ? 32'd1 : 32'd0);
            if (k == 8) check("t4_rsp_data", 32'(rsp_data), 32'hA5);
        end

        // 5: reset after grants R,G,R (ptr at G) -> outputs clear, no stale rsp, ptr back to R
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            req_valid = 3'b011;
            req_addr  = {8'h30, 8'h20, 8'h10};
            @(negedge clk);
            check("t5_ready", 32'(req_ready), (k % 2 == 0) ? 32'b001 : 32'b010);
        end
        @(posedge clk); #1;
        tb_rst = 1'b1;
        #1;
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        check("t5_rst_addr",  32'(rom_addr),  32'd0);
        check("t5_rst_rsp",   32'(rsp_valid), 32'd0);
        check("t5_rst_busy",  32'(busy),      32'd0);
        @(posedge clk); #1;
        tb_rst    = 1'b0;
        req_valid = 3'b000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_no_stale_rsp",  32'(rsp_valid), 32'd0);
            check("t5_no_stale_busy", 32'(busy),      32'd0);
            @(posedge clk); #1;
        end
        req_valid = 3'b011;
        @(negedge clk);
        check("t5_first_grant", 32'(req_ready), 32'b001);
        @(posedge clk); #1;
        req_valid = 3'b000;
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
